// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 passive matrix keypad scanner.
// Drives one active-low column at a time and samples the synchronized rows
// at the end of each column slot. It builds a 16-key snapshot per frame,
// debounces whole frames, and reports each new single-key press as a hex
// code with a one-cycle strobe.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0]       row_m, row_s;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             sample, frame_end;
  logic [3:0]       sample_bits;
  logic [15:0]      snap, prev, frame;
  logic [3:0]       stable_cnt, stable_nxt;
  logic             accepted;
  logic [4:0]       ones;
  logic [3:0]       one_idx;
  state_t           state, state_nxt;
  logic [3:0]       code_nxt;
  logic             valid_nxt;

  assign sample      = (div_cnt == DIV_LAST);
  assign frame_end   = sample && (col_idx == 2'd3);
  assign sample_bits = ~row_s;
  assign key_down    = (state == HELD);

  // Two-flop synchronizer for the asynchronous row inputs (idle = released)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row_n;
      row_s <= row_m;
    end
  end

  // Column slot timer and column index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= '0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Active-low one-hot column drive
  always_comb begin
    col_n = ~(4'b0001 << col_idx);
  end

  // Snapshot of the current frame, with column 3 taken from the live sample
  always_comb begin
    frame        = snap;
    frame[15:12] = sample_bits;
  end

  // Snapshot bits are laid out column-major: bit = col*4 + row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
    end else if (sample) begin
      snap[{col_idx, 2'b00} +: 4] <= sample_bits;
    end
  end

  // Saturating count of consecutive identical frames
  always_comb begin
    if (frame == prev) begin
      stable_nxt = (stable_cnt == DB) ? stable_cnt : stable_cnt + 4'd1;
    end else begin
      stable_nxt = '0;
    end
  end

  // Frame compare register; accepted pulses for one cycle after a frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      stable_cnt <= '0;
      accepted   <= 1'b0;
    end else if (frame_end) begin
      prev       <= frame;
      stable_cnt <= stable_nxt;
      accepted   <= (stable_nxt == DB);
    end else begin
      accepted   <= 1'b0;
    end
  end

  // Population count and index of the set bit of the accepted snapshot
  always_comb begin
    ones    = '0;
    one_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (prev[i]) begin
        ones    = ones + 5'd1;
        one_idx = 4'(i);
      end
    end
  end

  // Press/release FSM: next state, strobe and code
  always_comb begin
    state_nxt = state;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    if (accepted) begin
      unique case (state)
        IDLE: begin
          if (ones == 5'd1) begin
            state_nxt = HELD;
            // column-major snapshot index -> row*4 + col
            code_nxt  = {one_idx[1:0], one_idx[3:2]};
            valid_nxt = 1'b1;
          end
        end
        HELD: begin
          if (ones == 5'd0) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state, code and strobe registers; strobe and code change together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=2 (F=16).
// A keypad model drives row_n from col_n; a frame-history model predicts
// every output on every cycle.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed = '0;   // indexed by key code row*4+col

  int n_tests = 0;
  int n_fail  = 0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low through any pressed key whose column is driven
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  int unsigned m_k = 0;           // clock edges since reset release
  logic [15:0] h1 = '0, h2 = '0;  // key state one and two edges ago
  logic [15:0] mf = '0;           // frame being assembled, key-code order
  logic [15:0] frames[$];
  logic        m_valid = 1'b0, m_down = 1'b0;
  logic [3:0]  m_code = '0, m_col = 4'b1110, m_sh;
  logic        pend_valid = 1'b0, pend_release = 1'b0, m_acc;
  logic [3:0]  pend_code = '0;
  int          m_c, m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = 0; h1 = '0; h2 = '0; mf = '0;
      frames.delete(); frames.push_back(16'h0);
      m_valid = 1'b0; m_down = 1'b0; m_code = '0; m_col = 4'b1110;
      pend_valid = 1'b0; pend_release = 1'b0; pend_code = '0;
    end else begin
      m_k++;
      m_valid = pend_valid;
      if (pend_valid) begin m_code = pend_code; m_down = 1'b1; end
      if (pend_release) m_down = 1'b0;
      pend_valid = 1'b0; pend_release = 1'b0;
      if (m_k % SD == 0) begin
        m_c = int'((m_k / SD - 1) % 4);
        for (int r = 0; r < 4; r++) mf[r*4+m_c] = h2[r*4+m_c];
        if (m_c == 3) begin
          frames.push_back(mf);
          if (frames.size() > DB + 1) void'(frames.pop_front());
          m_acc = (frames.size() == DB + 1);
          foreach (frames[i]) if (frames[i] != frames[0]) m_acc = 1'b0;
          if (m_acc) begin
            if (!m_down && $countones(mf) == 1) begin
              m_idx = 0;
              for (int i = 0; i < 16; i++) if (mf[i]) m_idx = i;
              pend_valid = 1'b1; pend_code = 4'(m_idx);
            end else if (m_down && mf == 16'h0) begin
              pend_release = 1'b1;
            end
          end
        end
      end
      h2 = h1; h1 = pressed;
      m_sh = 4'b0001 << ((m_k / SD) % 4);
      m_col = ~m_sh;
    end
  end

  // ---------------- compare + monitor ----------------
  int strobes = 0, down_cycles = 0;
  int last_strobe_k = 0, fall_k = 0;
  logic prev_down = 1'b0;
  logic [3:0] codes[$];

  always @(negedge clk) begin
    n_tests++;
    if (key_valid !== m_valid || key_down !== m_down || key_code !== m_code || col_n !== m_col) begin
      n_fail++;
      $display("FAIL cycle k=%0d: got valid=%b down=%b code=%0d col_n=%b, want valid=%b down=%b code=%0d col_n=%b",
               m_k, key_valid, key_down, key_code, col_n, m_valid, m_down, m_code, m_col);
    end
    if (key_valid === 1'b1) begin
      strobes++; codes.push_back(key_code); last_strobe_k = int'(m_k);
    end
    if (key_down === 1'b1) down_cycles++;
    if (prev_down && key_down === 1'b0) fall_k = int'(m_k);
    prev_down = (key_down === 1'b1);
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int s0, press_k, rel_k, lat, want, waited;

  initial begin
    // reset state
    @(posedge clk); #2;
    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_down", int'(key_down), 0);
    step(2);
    rst = 1'b0;

    // column sequence for the first frame after reset release
    for (int i = 1; i <= 16; i++) begin
      step(1);
      want = (i < 4) ? 4'b1110 : (i < 8) ? 4'b1101 : (i < 12) ? 4'b1011 : (i < 16) ? 4'b0111 : 4'b1110;
      check("col_seq", int'(col_n), want);
    end
    while (m_k < 200) step(1);
    check("idle_strobes", strobes, 0);
    check("idle_down_cycles", down_cycles, 0);

    // single press of (r2,c1) with latency checks; press/release aligned in column 1 slot
    s0 = strobes;
    while (m_k % 16 != 5) step(1);
    press_k = int'(m_k);
    pressed[9] = 1'b1;
    step(300);
    while (m_k % 16 != 5) step(1);
    check("held_down", int'(key_down), 1);
    rel_k = int'(m_k);
    pressed[9] = 1'b0;
    step(100);
    check("press_strobes", strobes - s0, 1);
    check("press_code", int'(codes[$]), 9);
    lat = last_strobe_k - press_k;
    check("press_latency", lat, 44);
    check("press_latency_window", int'(lat >= 33 && lat <= 51), 1);
    lat = fall_k - rel_k;
    check("release_latency", lat, 44);
    check("released_down", int'(key_down), 0);

    // sequential presses
    s0 = strobes;
    pressed[0] = 1'b1;  step(150); pressed = '0; step(150);
    pressed[15] = 1'b1; step(150); pressed = '0; step(150);
    pressed[6] = 1'b1;  step(150); pressed = '0; step(150);
    check("seq_strobes", strobes - s0, 3);
    check("seq_code0", int'(codes[codes.size()-3]), 0);
    check("seq_code1", int'(codes[codes.size()-2]), 15);
    check("seq_code2", int'(codes[codes.size()-1]), 6);

    // bounce on (r1,c1), then a clean hold
    s0 = strobes;
    while (m_k % 4 != 2) step(1);
    for (int t = 0; t < 10; t++) begin
      pressed[5] = ~pressed[5];
      step(10);
    end
    check("bounce_strobes", strobes - s0, 0);
    pressed[5] = 1'b1; step(150);
    check("bounce_hold_strobes", strobes - s0, 1);
    check("bounce_code", int'(key_code), 5);
    pressed = '0; step(150);

    // two keys, release one, then add another while held
    s0 = strobes;
    pressed[1] = 1'b1; pressed[11] = 1'b1; step(150);
    check("multi_no_strobe", strobes - s0, 0);
    check("multi_not_down", int'(key_down), 0);
    pressed[11] = 1'b0; step(150);
    check("multi_single_strobe", strobes - s0, 1);
    check("multi_code", int'(key_code), 1);
    pressed[12] = 1'b1; step(150);
    check("multi_add_no_strobe", strobes - s0, 1);
    check("multi_add_down", int'(key_down), 1);
    check("multi_add_code", int'(key_code), 1);
    pressed = '0; step(150);
    check("multi_release_down", int'(key_down), 0);

    // reset mid-frame while a key is held
    pressed[14] = 1'b1;
    waited = 0;
    while (key_down !== 1'b1 && waited < 100) begin step(1); waited++; end
    check("pre_reset_down", int'(key_down), 1);
    while (m_k % 16 != 6) step(1);
    rst = 1'b1;
    #1;
    check("midrst_col_n", int'(col_n), 4'b1110);
    check("midrst_key_down", int'(key_down), 0);
    check("midrst_key_valid", int'(key_valid), 0);
    check("midrst_key_code", int'(key_code), 0);
    step(3);
    rst = 1'b0;
    s0 = strobes;
    step(150);
    check("post_reset_strobes", strobes - s0, 1);
    check("post_reset_code", int'(key_code), 14);
    pressed = '0; step(150);
    check("post_reset_release", int'(key_down), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner for a 4x4 passive matrix keypad, the input-side counterpart of the board's time-multiplexed 7-segment driver. It drives one column at a time and samples the rows, building a full 16-key snapshot per scan frame. The snapshot is debounced over whole frames, and each new single-key press is reported as a 4-bit hex code with a one-cycle valid strobe. The code feeds the existing seg7 decoding and display path.

## Interface
- SCAN_DIV, 50000: clock cycles each column stays driven (0.5 ms at 100 MHz); must be at least 4.
- DEBOUNCE, 8: consecutive identical frames required before a snapshot is accepted; range 1..15.
- clk  in  1  system clock, all logic on rising edge; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- col_n  out  4  column drive, active low, exactly one bit low at any time.
- row_n  in  4  row sense, active low (board pull-ups), asynchronous to clk.
- key_code  out  4  code of last accepted key = row_index*4 + col_index.
- key_valid  out  1  one-cycle strobe; key_code is updated in the same cycle.
- key_down  out  1  high while an accepted key is held (state HELD).

## Operation
- Synchronizer: row_n passes through 2 flops to give row_s. Only row_s is used downstream.
- Scan counter: div_cnt counts 0..SCAN_DIV-1. col_idx (0..3) advances and wraps 3->0 when div_cnt == SCAN_DIV-1. col_n = ~(1 << col_idx).
- Sample point: the cycle where div_cnt == SCAN_DIV-1, before col_idx advances. On that cycle, snap[col_idx*4+r] <= ~row_s[r] for r = 0..3. The other bits hold.
- Frame end: the sample cycle with col_idx == 3. frame = snap with the column-3 bits replaced by the current sample.
- Frame compare at frame end:
  - If frame == prev, stable_cnt increments, saturating at DEBOUNCE.
  - Otherwise stable_cnt <= 0.
  - prev <= frame in both cases.
- Accepted frame: the new stable_cnt equals DEBOUNCE.
  - The FSM evaluates in the cycle after frame end, using registered accepted and prev.
  - The FSM ignores frames that are not accepted.
- FSM:
  - IDLE -> HELD when an accepted frame has exactly one bit set. In the same cycle: key_code <= index of that bit, key_valid = 1.
  - IDLE stays IDLE when an accepted frame has zero bits or two or more bits set. No strobe.
  - HELD -> IDLE when an accepted frame has zero bits set.
  - HELD stays HELD for any nonzero accepted frame, including a different key or multiple keys. No strobe; key_code holds.
- key_down = (state == HELD). key_valid is high only on the IDLE->HELD transition cycle.
- Reset (any time, including mid-scan or mid-press):
  - col_n = 4'b1110, key_code = 0, key_valid = 0, key_down = 0.
  - div_cnt, col_idx, snap, prev and stable_cnt = 0; state = IDLE; synchronizer flops = 1.
  - A key still held at release of reset is reported once it has debounced.

## Timing
- Frame length F = 4*SCAN_DIV cycles. col_n changes on the cycle after each sample point.
- Row settling: at least SCAN_DIV-3 cycles between a column change and its sample, including 2 synchronizer cycles.
- Press latency from a clean press to key_valid: between DEBOUNCE*F+1 and (DEBOUNCE+1)*F+3 cycles.
  - The first frame containing the key resets stable_cnt.
  - DEBOUNCE further identical frames are then required.
- Release latency to the key_down fall: in the same DEBOUNCE*F+1 to (DEBOUNCE+1)*F+3 window.
- A change on row_n or col_n that reverts before the next sample of the affected column is invisible.
- A snapshot that differs within any DEBOUNCE-frame window is never accepted.
- stable_cnt saturation: an indefinitely held key produces exactly one strobe.

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE=2 (F=16). Keypad model: row_n[r] = AND over pressed (r,c) of col_n[c], 1 if no key is pressed.

- Reset, no keys -> col_n cycles 1110, 1101, 1011, 0111, each for 4 cycles; key_valid and key_down stay 0 for 200 cycles.
- Press (r2,c1) at cycle 10 and hold 300 cycles -> exactly one key_valid, key_code = 9, inside latency window [33, 51] after press. key_down = 1 until release plus 33..51 cycles, then 0.
- Sequential presses (r0,c0), (r3,c3), (r1,c2), each separated by release -> codes 0, 15, 6, one strobe each.
- Bounce: toggle (r1,c1) every 10 cycles for 100 cycles, then hold -> no strobe during bouncing; one strobe with key_code = 5 after the hold debounces.
- Press (r0,c1) and (r2,c3) together -> no strobe. Release (r2,c3) -> one strobe, key_code = 1. Add (r3,c0) while HELD -> no strobe.
- Hold (r3,c2) and assert rst for 3 cycles mid-frame while key_down = 1 -> all outputs return to reset values immediately. After release of rst, one new strobe with key_code = 14.
